datapath_sequencer: RTL and testbench
=====================================

// Module: datapath_sequencer
// PURPOSE
//  Multi-cycle controller for the register-file / MUX2_1 / ULA datapath.
//  - Accepts one ALU instruction at a time over a valid/ready handshake.
//  - Drives the register-file read/write ports, the SrcB mux select, the constant and ULAControl.
//  - Captures ULAResult and FlagZ, optionally writes the result back, then pulses done.
//  - Replaces the manual switch/key stepping of the datapath test top.
// PARAMETERS
//  DATA_W  8   datapath width (wd3/rd1/rd2/ULAResult)
//  ADDR_W  3   register address width (ra1/ra2/wa3)
//  OP_W    3   ULAControl width
//  CNT_W   16  executed-instruction counter width
// PORTS
//  clk           in   1       rising-edge clock
//  rst_n         in   1       asynchronous, active-low reset
//  instr_valid   in   1       instruction present; fields held stable until accepted
//  instr_ready   out  1       high only in IDLE; accept = valid & ready at clk edge
//  instr_op      in   OP_W    ULAControl code
//  instr_dst     in   ADDR_W  write-back register
//  instr_srca    in   ADDR_W  SrcA register (ra1)
//  instr_srcb    in   ADDR_W  SrcB register (ra2)
//  instr_imm_sel in   1       1: SrcB = instr_imm (mux Sel=1), 0: SrcB = rd2
//  instr_imm     in   DATA_W  constant operand
//  instr_wb      in   1       1: write result to instr_dst
//  instr_skipz   in   1       1: skip instruction if flag_z is currently 1
//  rf_ra1/rf_ra2 out  ADDR_W  register-file read addresses
//  rf_wa3        out  ADDR_W  register-file write address
//  rf_we3        out  1       register-file write enable
//  rf_wd3        out  DATA_W  register-file write data
//  mux_sel       out  1       SrcB mux select
//  imm_out       out  DATA_W  constant to mux B input
//  alu_ctrl      out  OP_W    ULAControl
//  alu_result    in   DATA_W  ULAResult
//  alu_flagz     in   1       ULA FlagZ
//  busy          out  1       state != IDLE
//  done          out  1       one-cycle pulse at instruction completion
//  done_skipped  out  1       qualifies done: instruction was skipped
//  result        out  DATA_W  last captured ULAResult
//  flag_z        out  1       last captured FlagZ (sticky)
//  instr_count   out  CNT_W   executed (non-skipped) instructions
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except instr_ready=1. Latched fields cleared.
//  FSM states:
//  - IDLE: on accept, latch all fields.
//      skipz & flag_z -> DONE (skip). Otherwise -> READ.
//  - READ: drive ra1/ra2/mux_sel/imm_out/alu_ctrl from the latch. -> EXEC
//  - EXEC: same drive.
//      At the end of the cycle: result<=alu_result, flag_z<=alu_flagz, instr_count++.
//      wb -> WRITE, else -> DONE.
//  - WRITE: rf_we3=1, rf_wa3=dst, rf_wd3=result; the register file writes at this edge. -> DONE
//  - DONE: done=1; done_skipped=1 iff skipped. -> IDLE
//  Output timing:
//  - ra/alu/mux outputs hold their latched values from READ through DONE.
//  - rf_we3 is a registered flag: high in exactly one cycle, glitch-free.
//  Latency, from accept edge to done high: wb=1 4 cycles; wb=0 3 cycles; skipped 1 cycle.
//  Back-to-back throughput: one instruction per 5 (wb) / 4 / 2 cycles.
//  Skip: result, flag_z, instr_count and the register file are unchanged.
//  Boundary conditions:
//  - dst==srca/srcb is legal: operands are captured before the write.
//  - instr_valid while busy is ignored; no queueing.
//  - Fields changing while instr_ready=0 have no effect.
//  - instr_count wraps 2^CNT_W-1 -> 0.
//  - Reset mid-instruction: rf_we3/done/busy drop asynchronously; the instruction is
//    abandoned with no done. A write occurs only if a clk edge in WRITE preceded reset.
// STRUCTURE
//  Shared package (dp_seq_pkg):
//  - state encoding (IDLE, READ, EXEC, WRITE, DONE)
//  - ULA opcodes: AND=3'b000, OR=3'b001, ADD=3'b010, SUB=3'b110, SLT=3'b111
//  - field widths
//  One sub-module: seq_instr_reg (accept-qualified instruction latch, async clear).
//  FSM, capture registers and counter stay inline.
// TESTING (bench instantiates RegisterFile, MUX2_1, ULA with this block)
//  1. Reset mid-WRITE (r1 holds 0x05, executing ADD r1,r2,imm 0x01, wb) -> rf_we3 low
//     immediately, no done, r1 stays 0x05, instr_count=0, instr_ready=1 after release.
//  2. r2=0x05, r3=0x03; ADD dst=r1,srca=r2,srcb=r3,wb=1
//     -> done 4 cycles after accept, result=0x08, flag_z=0, r1=0x08, instr_count=1.
//  3. r2=0x07; SUB r4 = r2 - imm 0x07 (imm_sel=1), wb=1
//     -> mux_sel=1, result=0x00, flag_z=1, r4=0x00.
//  4. After 3, skipz=1 ADD r5
//     -> done and done_skipped 1 cycle after accept, r5 unchanged, instr_count unchanged.
//  5. wb=0 OR r2|r3 (0x07|0x03), instr_valid held high while busy
//     -> result=0x07, rf_we3 never high, done at 3 cycles, only one accept.
//  6. Preload instr_count=0xFFFF via 65535 back-to-back wb=0 ops, then one more
//     -> instr_count=0x0000.

Source files
------------

// File: rtl/dp_seq_pkg.sv
// Shared definitions for the datapath sequencer: FSM states, ULA opcodes
// and the default field widths of the register-file / MUX2_1 / ULA datapath.
package dp_seq_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_OP_W   = 3;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [DEF_OP_W-1:0] OP_AND = 3'b000;
  localparam logic [DEF_OP_W-1:0] OP_OR  = 3'b001;
  localparam logic [DEF_OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [DEF_OP_W-1:0] OP_SUB = 3'b110;
  localparam logic [DEF_OP_W-1:0] OP_SLT = 3'b111;

endpackage

// File: rtl/datapath_sequencer_instr_reg.sv
// Instruction latch: captures the instruction fields on the accept edge and
// holds them for the whole instruction, so the source may change its fields
// freely once the handshake has completed.
module seq_instr_reg
  import dp_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int OP_W   = DEF_OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accept,
  input  logic [OP_W-1:0]   op,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] srca,
  input  logic [ADDR_W-1:0] srcb,
  input  logic              imm_sel,
  input  logic [DATA_W-1:0] imm,
  input  logic              wb,
  output logic [OP_W-1:0]   q_op,
  output logic [ADDR_W-1:0] q_dst,
  output logic [ADDR_W-1:0] q_srca,
  output logic [ADDR_W-1:0] q_srcb,
  output logic              q_imm_sel,
  output logic [DATA_W-1:0] q_imm,
  output logic              q_wb
);

  // Load all fields on accept; cleared by reset so idle outputs read as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_op      <= '0;
      q_dst     <= '0;
      q_srca    <= '0;
      q_srcb    <= '0;
      q_imm_sel <= 1'b0;
      q_imm     <= '0;
      q_wb      <= 1'b0;
    end else if (accept) begin
      q_op      <= op;
      q_dst     <= dst;
      q_srca    <= srca;
      q_srcb    <= srcb;
      q_imm_sel <= imm_sel;
      q_imm     <= imm;
      q_wb      <= wb;
    end
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle controller for the register-file / MUX2_1 / ULA datapath.
// One instruction at a time: IDLE -> READ -> EXEC -> [WRITE] -> DONE, or
// IDLE -> DONE when a skip-if-zero instruction finds the flag set.
module datapath_sequencer
  import dp_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int OP_W   = DEF_OP_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [ADDR_W-1:0] instr_dst,
  input  logic [ADDR_W-1:0] instr_srca,
  input  logic [ADDR_W-1:0] instr_srcb,
  input  logic              instr_imm_sel,
  input  logic [DATA_W-1:0] instr_imm,
  input  logic              instr_wb,
  input  logic              instr_skipz,
  output logic [ADDR_W-1:0] rf_ra1,
  output logic [ADDR_W-1:0] rf_ra2,
  output logic [ADDR_W-1:0] rf_wa3,
  output logic              rf_we3,
  output logic [DATA_W-1:0] rf_wd3,
  output logic              mux_sel,
  output logic [DATA_W-1:0] imm_out,
  output logic [OP_W-1:0]   alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_flagz,
  output logic              busy,
  output logic              done,
  output logic              done_skipped,
  output logic [DATA_W-1:0] result,
  output logic              flag_z,
  output logic [CNT_W-1:0]  instr_count
);

  state_t state;
  logic   accept;
  logic   lat_wb;

  assign accept = instr_valid & instr_ready;

  // Operand addresses, mux select, constant and opcode come straight from the
  // latch, so they are stable from READ through DONE and hold afterwards.
  seq_instr_reg #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .OP_W   (OP_W)
  ) u_instr_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .accept    (accept),
    .op        (instr_op),
    .dst       (instr_dst),
    .srca      (instr_srca),
    .srcb      (instr_srcb),
    .imm_sel   (instr_imm_sel),
    .imm       (instr_imm),
    .wb        (instr_wb),
    .q_op      (alu_ctrl),
    .q_dst     (rf_wa3),
    .q_srca    (rf_ra1),
    .q_srcb    (rf_ra2),
    .q_imm_sel (mux_sel),
    .q_imm     (imm_out),
    .q_wb      (lat_wb)
  );

  // Write-back data is the captured result, already stable when WRITE begins
  assign rf_wd3 = result;

  // Sequencer FSM with registered handshake/strobe outputs, result capture and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      instr_ready  <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      done_skipped <= 1'b0;
      rf_we3       <= 1'b0;
      result       <= '0;
      flag_z       <= 1'b0;
      instr_count  <= '0;
    end else begin
      done         <= 1'b0;
      done_skipped <= 1'b0;
      rf_we3       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            instr_ready <= 1'b0;
            busy        <= 1'b1;
            // Skip decision uses the flag captured by the previous instruction
            if (instr_skipz && flag_z) begin
              state        <= ST_DONE;
              done         <= 1'b1;
              done_skipped <= 1'b1;
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          result      <= alu_result;
          flag_z      <= alu_flagz;
          instr_count <= instr_count + CNT_W'(1);
          if (lat_wb) begin
            state  <= ST_WRITE;
            rf_we3 <= 1'b1;
          end else begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_WRITE: begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        ST_DONE: begin
          state       <= ST_IDLE;
          instr_ready <= 1'b1;
          busy        <= 1'b0;
        end
        default: begin
          state       <= ST_IDLE;
          instr_ready <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: surrounds the sequencer with a behavioural
// register file, SrcB mux and ULA, and predicts every instruction from an
// architectural model (register array, flag, result, counter).
module tb_datapath_sequencer;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int OW = 3;
  // Narrow counter so the wrap-around is reachable in a short run
  localparam int TB_CNT_W = 8;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] dst;
    logic [2:0] srca;
    logic [2:0] srcb;
    logic       imm_sel;
    logic [7:0] imm;
    logic       wb;
    logic       skipz;
  } ins_t;

  typedef struct {
    ins_t       ins;
    bit         hold;
    logic [7:0] exp_result;
    logic       exp_z;
    int         exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic instr_valid = 1'b0;
  logic instr_ready;
  logic [OW-1:0] instr_op = '0;
  logic [AW-1:0] instr_dst = '0, instr_srca = '0, instr_srcb = '0;
  logic instr_imm_sel = 1'b0;
  logic [DW-1:0] instr_imm = '0;
  logic instr_wb = 1'b0, instr_skipz = 1'b0;
  logic [AW-1:0] rf_ra1, rf_ra2, rf_wa3;
  logic rf_we3;
  logic [DW-1:0] rf_wd3, imm_out, alu_result, result;
  logic mux_sel, alu_flagz, busy, done, done_skipped, flag_z;
  logic [OW-1:0] alu_ctrl;
  logic [TB_CNT_W-1:0] instr_count;

  // Environment: register file, SrcB mux, ULA
  logic [7:0] rf [8];
  logic ld_en = 1'b0;
  logic [2:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic [7:0] rd1, rd2, srcb_val;

  // Architectural model state
  logic [7:0] m_rf [8];
  logic [7:0] m_result;
  logic       m_flag;
  int         m_count;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rf_we3) rf[rf_wa3] <= rf_wd3;
    else if (ld_en) rf[ld_addr] <= ld_data;
  end

  assign rd1 = rf[rf_ra1];
  assign rd2 = rf[rf_ra2];
  assign srcb_val = mux_sel ? imm_out : rd2;
  assign alu_result = alu_f(alu_ctrl, rd1, srcb_val);
  assign alu_flagz = (alu_result == 8'd0);

  datapath_sequencer #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .OP_W   (OW),
    .CNT_W  (TB_CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_op      (instr_op),
    .instr_dst     (instr_dst),
    .instr_srca    (instr_srca),
    .instr_srcb    (instr_srcb),
    .instr_imm_sel (instr_imm_sel),
    .instr_imm     (instr_imm),
    .instr_wb      (instr_wb),
    .instr_skipz   (instr_skipz),
    .rf_ra1        (rf_ra1),
    .rf_ra2        (rf_ra2),
    .rf_wa3        (rf_wa3),
    .rf_we3        (rf_we3),
    .rf_wd3        (rf_wd3),
    .mux_sel       (mux_sel),
    .imm_out       (imm_out),
    .alu_ctrl      (alu_ctrl),
    .alu_result    (alu_result),
    .alu_flagz     (alu_flagz),
    .busy          (busy),
    .done          (done),
    .done_skipped  (done_skipped),
    .result        (result),
    .flag_z        (flag_z),
    .instr_count   (instr_count)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en = 1'b1;
    @(posedge clk);
    #1 ld_en = 1'b0;
    m_rf[a] = d;
    @(negedge clk);
  endtask

  task automatic drive(input ins_t in);
    instr_op = in.op;
    instr_dst = in.dst;
    instr_srca = in.srca;
    instr_srcb = in.srcb;
    instr_imm_sel = in.imm_sel;
    instr_imm = in.imm;
    instr_wb = in.wb;
    instr_skipz = in.skipz;
  endtask

  // What the architecture says this instruction yields, from current model state
  task automatic predict(input ins_t in, output logic [7:0] er, output logic ez, output int elat);
    logic [7:0] b;
    if (in.skipz && m_flag) begin
      er = m_result;
      ez = m_flag;
      elat = 1;
    end else begin
      b = in.imm_sel ? in.imm : m_rf[in.srcb];
      er = alu_f(in.op, m_rf[in.srca], b);
      ez = (er == 8'd0);
      elat = in.wb ? 4 : 3;
    end
  endtask

  // Issue one instruction at a negedge in IDLE; returns at a negedge back in IDLE
  task automatic run_instr(input ins_t in, input bit hold, input logic [7:0] er,
                           input logic ez, input int elat);
    bit skip;
    int cyc;
    int we_cnt;
    bit got;
    logic [7:0] b;
    skip = in.skipz && m_flag;
    check("ready_before_issue", {31'd0, instr_ready}, 32'd1);
    drive(in);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) instr_valid = 1'b0;
    // Scramble fields while busy: they must have no effect
    drive(ins_t'($urandom));
    if (!skip) begin
      b = in.imm_sel ? in.imm : m_rf[in.srcb];
      m_result = alu_f(in.op, m_rf[in.srca], b);
      m_flag = (m_result == 8'd0);
      m_count = (m_count + 1) % (CNT_MAX + 1);
      if (in.wb) m_rf[in.dst] = m_result;
    end
    cyc = 0;
    we_cnt = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (rf_we3) we_cnt++;
      if (instr_ready && !done) check("ready_low_while_busy", {31'd0, instr_ready}, 32'd0);
      if (done) got = 1'b1;
    end
    instr_valid = 1'b0;
    check("done_seen", {31'd0, got}, 32'd1);
    check("latency", cyc, elat);
    check("done_skipped", {31'd0, done_skipped}, {31'd0, skip});
    check("result", {24'd0, result}, {24'd0, er});
    check("flag_z", {31'd0, flag_z}, {31'd0, ez});
    check("instr_count", {24'd0, instr_count}, m_count);
    check("we_pulses", we_cnt, (in.wb && !skip) ? 1 : 0);
    check("mux_sel_held", {31'd0, mux_sel}, {31'd0, in.imm_sel});
    check("alu_ctrl_held", {29'd0, alu_ctrl}, {29'd0, in.op});
    for (int i = 0; i < 8; i++) check($sformatf("rf_r%0d", i), {24'd0, rf[i]}, {24'd0, m_rf[i]});
    @(negedge clk);
    check("busy_after", {31'd0, busy}, 32'd0);
    check("ready_after", {31'd0, instr_ready}, 32'd1);
    check("single_accept", {24'd0, instr_count}, m_count);
  endtask

  function automatic ins_t mk(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] sa,
                              input logic [2:0] sb, input logic isel, input logic [7:0] imm,
                              input logic wb, input logic skz);
    ins_t r;
    r.op = op; r.dst = dst; r.srca = sa; r.srcb = sb;
    r.imm_sel = isel; r.imm = imm; r.wb = wb; r.skipz = skz;
    return r;
  endfunction

  initial begin
    vec_t vecs [7];
    logic [7:0] er;
    logic ez;
    int elat;
    int wait_cyc;
    ins_t ri;
    logic [2:0] ops [5];
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b110; ops[4] = 3'b111;

    for (int i = 0; i < 8; i++) begin
      rf[i] = 8'd0;
      m_rf[i] = 8'd0;
    end
    m_result = 8'd0;
    m_flag = 1'b0;
    m_count = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_we3", {31'd0, rf_we3}, 32'd0);
    check("rst_outs", {rf_ra1, rf_ra2, rf_wa3, mux_sel, alu_ctrl, imm_out, result}, 32'd0);
    check("rst_count", {24'd0, instr_count}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of WRITE: the write must not happen
    preload(3'd1, 8'h05);
    preload(3'd2, 8'h05);
    preload(3'd3, 8'h03);
    drive(mk(3'b010, 3'd1, 3'd2, 3'd0, 1'b1, 8'h01, 1'b1, 1'b0));
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    wait_cyc = 0;
    while (!rf_we3 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("midwrite_we3_seen", {31'd0, rf_we3}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midwrite_we3_drop", {31'd0, rf_we3}, 32'd0);
    check("midwrite_busy_drop", {31'd0, busy}, 32'd0);
    check("midwrite_done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midwrite_no_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midwrite_r1", {24'd0, rf[1]}, 32'h05);
    check("midwrite_count", {24'd0, instr_count}, 32'd0);
    check("midwrite_ready", {31'd0, instr_ready}, 32'd1);
    check("midwrite_no_done2", {31'd0, done}, 32'd0);
    m_result = 8'd0;
    m_flag = 1'b0;
    m_count = 0;

    // Directed vectors (state chains from row to row): r1=5 r2=5 r3=3
    vecs[0] = '{mk(3'b010, 3'd1, 3'd2, 3'd3, 1'b0, 8'h00, 1'b1, 1'b0), 1'b0, 8'h08, 1'b0, 4}; // ADD r1=r2+r3
    vecs[1] = '{mk(3'b001, 3'd2, 3'd2, 3'd0, 1'b1, 8'h07, 1'b1, 1'b0), 1'b0, 8'h07, 1'b0, 4}; // OR r2=r2|7
    vecs[2] = '{mk(3'b110, 3'd4, 3'd2, 3'd0, 1'b1, 8'h07, 1'b1, 1'b0), 1'b0, 8'h00, 1'b1, 4}; // SUB r4=r2-7
    vecs[3] = '{mk(3'b010, 3'd5, 3'd2, 3'd3, 1'b0, 8'h00, 1'b1, 1'b1), 1'b0, 8'h00, 1'b1, 1}; // skipped
    vecs[4] = '{mk(3'b001, 3'd6, 3'd2, 3'd3, 1'b0, 8'h00, 1'b0, 1'b0), 1'b1, 8'h07, 1'b0, 3}; // OR no wb, valid held
    vecs[5] = '{mk(3'b111, 3'd7, 3'd3, 3'd2, 1'b0, 8'h00, 1'b1, 1'b0), 1'b0, 8'h01, 1'b0, 4}; // SLT r7=(3<7)
    vecs[6] = '{mk(3'b110, 3'd5, 3'd2, 3'd3, 1'b0, 8'h00, 1'b1, 1'b1), 1'b0, 8'h04, 1'b0, 4}; // skipz, flag clear
    for (int i = 0; i < 7; i++) begin
      run_instr(vecs[i].ins, vecs[i].hold, vecs[i].exp_result, vecs[i].exp_z, vecs[i].exp_lat);
    end
    check("seq_r1", {24'd0, rf[1]}, 32'h08);
    check("seq_r4", {24'd0, rf[4]}, 32'h00);
    check("seq_r5", {24'd0, rf[5]}, 32'h04);

    // Randomized instructions against the model
    for (int i = 0; i < 60; i++) begin
      ri = ins_t'($urandom);
      ri.op = ops[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) ri.imm = 8'h00;
      predict(ri, er, ez, elat);
      run_instr(ri, 1'($urandom_range(0, 1)), er, ez, elat);
    end

    // Drive the counter to its maximum, then wrap it
    while (m_count != CNT_MAX) begin
      ri = mk(3'b001, 3'd0, 3'd1, 3'd2, 1'b0, 8'h00, 1'b0, 1'b0);
      predict(ri, er, ez, elat);
      run_instr(ri, 1'b0, er, ez, elat);
    end
    check("count_at_max", {24'd0, instr_count}, CNT_MAX);
    ri = mk(3'b010, 3'd0, 3'd1, 3'd2, 1'b0, 8'h00, 1'b0, 1'b0);
    predict(ri, er, ez, elat);
    run_instr(ri, 1'b0, er, ez, elat);
    check("count_wrapped", {24'd0, instr_count}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
